// File: rtl/hazard_sequencer_pkg.sv
// Shared control definitions for the pipeline hazard sequencer:
// FSM states, forwarding-select encodings and the load result-select value.
package hazard_sequencer_pkg;

   typedef enum logic [1:0] {
      FILL     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] FWD_REGFILE     = 2'b00;
   localparam logic [1:0] FWD_WB          = 2'b01;
   localparam logic [1:0] FWD_MEM         = 2'b10;
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // A producer register matches a consumer only when it is not x0.
   function automatic logic reg_match(input logic [4:0] producer, input logic [4:0] consumer);
      return (producer != 5'd0) && (producer == consumer);
   endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline <-> hazard sequencer bundle. The pipeline side is the master,
// the sequencer is the slave; o_state is a debug view of the FSM.
interface hazard_sequencer_if;
   import hazard_sequencer_pkg::*;

   logic [4:0] i_d_rs1;
   logic [4:0] i_d_rs2;
   logic [4:0] i_e_rs1;
   logic [4:0] i_e_rs2;
   logic [4:0] i_e_rd;
   logic [4:0] i_m_rd;
   logic [4:0] i_w_rd;
   logic       i_m_en_regfile_write;
   logic       i_w_en_regfile_write;
   logic [1:0] i_e_mux_final_result_src;
   logic       i_pc_src;
   // Memory handshake: i_m_mem_req is held high while the mem stage owns a
   // load/store; i_mem_ack pulses high in the cycle the access completes.
   // A request with ack in the same cycle completes without stalling.
   logic       i_m_mem_req;
   logic       i_mem_ack;

   logic       o_f_stall;
   logic       o_d_stall;
   logic       o_e_stall;
   logic       o_m_stall;
   logic       o_fd_clr;
   logic       o_de_clr;
   logic       o_w_bubble;
   logic [1:0] o_fwd_a;
   logic [1:0] o_fwd_b;
   logic       o_mem_timeout;
   logic [15:0] o_stall_count;
   state_t     o_state;

   modport master (
      output i_d_rs1, i_d_rs2, i_e_rs1, i_e_rs2, i_e_rd, i_m_rd, i_w_rd,
             i_m_en_regfile_write, i_w_en_regfile_write,
             i_e_mux_final_result_src, i_pc_src, i_m_mem_req, i_mem_ack,
      input  o_f_stall, o_d_stall, o_e_stall, o_m_stall, o_fd_clr, o_de_clr,
             o_w_bubble, o_fwd_a, o_fwd_b, o_mem_timeout, o_stall_count, o_state
   );

   modport slave (
      input  i_d_rs1, i_d_rs2, i_e_rs1, i_e_rs2, i_e_rd, i_m_rd, i_w_rd,
             i_m_en_regfile_write, i_w_en_regfile_write,
             i_e_mux_final_result_src, i_pc_src, i_m_mem_req, i_mem_ack,
      output o_f_stall, o_d_stall, o_e_stall, o_m_stall, o_fd_clr, o_de_clr,
             o_w_bubble, o_fwd_a, o_fwd_b, o_mem_timeout, o_stall_count, o_state
   );

endinterface

// File: rtl/hazard_sequencer_forward_unit.sv
// Combinational operand forwarding for the exec stage; mem beats writeback.
module forward_unit
   import hazard_sequencer_pkg::*;
(
   input  logic       en,
   input  logic [4:0] e_rs1,
   input  logic [4:0] e_rs2,
   input  logic [4:0] m_rd,
   input  logic [4:0] w_rd,
   input  logic       m_we,
   input  logic       w_we,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   function automatic logic [1:0] pick(input logic [4:0] rs, input logic [4:0] mrd,
                                       input logic mwe, input logic [4:0] wrd,
                                       input logic wwe);
      if (mwe && reg_match(mrd, rs))
         return FWD_MEM;
      else if (wwe && reg_match(wrd, rs))
         return FWD_WB;
      else
         return FWD_REGFILE;
   endfunction

   always_comb begin
      fwd_a = FWD_REGFILE;
      fwd_b = FWD_REGFILE;
      if (en) begin
         fwd_a = pick(e_rs1, m_rd, m_we, w_rd, w_we);
         fwd_b = pick(e_rs2, m_rd, m_we, w_rd, w_we);
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard sequencer: pipeline fill, load-use stall, branch flush, memory wait
// with sticky timeout, and a saturating stall-cycle counter.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input logic         i_clk,
   input logic         i_rst,
   hazard_sequencer_if.slave bus
);

   localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

   state_t      state;
   logic [1:0]  fill_cnt;
   logic [3:0]  wait_cnt;
   logic        mem_timeout;
   logic [15:0] stall_count;

   logic load_use;
   logic in_run;
   logic in_wait;
   logic in_fill;
   logic f_stall;
   logic d_stall;
   logic fd_clr;
   logic de_clr;

   assign in_run  = i_rst && (state == RUN);
   assign in_wait = i_rst && (state == MEM_WAIT);
   assign in_fill = state == FILL;

   assign load_use = (bus.i_e_mux_final_result_src == RESULT_SRC_LOAD) &&
                     (reg_match(bus.i_e_rd, bus.i_d_rs1) || reg_match(bus.i_e_rd, bus.i_d_rs2));

   // A taken branch squashes the instruction that would otherwise stall.
   assign f_stall = in_wait || (in_run && load_use && !bus.i_pc_src);
   assign d_stall = f_stall;
   assign fd_clr  = !i_rst || in_fill || (in_run && bus.i_pc_src);
   assign de_clr  = !i_rst || in_fill || (in_run && (bus.i_pc_src || load_use));

   assign bus.o_f_stall     = f_stall;
   assign bus.o_d_stall     = d_stall;
   assign bus.o_e_stall     = in_wait;
   assign bus.o_m_stall     = in_wait;
   assign bus.o_w_bubble    = in_wait;
   assign bus.o_fd_clr      = fd_clr;
   assign bus.o_de_clr      = de_clr;
   assign bus.o_mem_timeout = mem_timeout;
   assign bus.o_stall_count = stall_count;
   assign bus.o_state       = state;

   forward_unit u_forward_unit (
      .en    (i_rst),
      .e_rs1 (bus.i_e_rs1),
      .e_rs2 (bus.i_e_rs2),
      .m_rd  (bus.i_m_rd),
      .w_rd  (bus.i_w_rd),
      .m_we  (bus.i_m_en_regfile_write),
      .w_we  (bus.i_w_en_regfile_write),
      .fwd_a (bus.o_fwd_a),
      .fwd_b (bus.o_fwd_b)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state       <= FILL;
         fill_cnt    <= 2'd0;
         wait_cnt    <= 4'd0;
         mem_timeout <= 1'b0;
         stall_count <= 16'd0;
      end else begin
         if (f_stall && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
         case (state)
            FILL: begin
               fill_cnt <= fill_cnt + 2'd1;
               if (fill_cnt == 2'd1) begin
                  state    <= RUN;
                  fill_cnt <= 2'd0;
               end
            end
            RUN: begin
               if (bus.i_m_mem_req && !bus.i_mem_ack) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 4'd0;
               end
            end
            MEM_WAIT: begin
               // Counter freezes at TIMEOUT; the flag stays until reset.
               if (wait_cnt != TIMEOUT_CNT) begin
                  wait_cnt <= wait_cnt + 4'd1;
                  if ((wait_cnt + 4'd1) == TIMEOUT_CNT)
                     mem_timeout <= 1'b1;
               end
               if (bus.i_mem_ack)
                  state <= RUN;
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: reset, fill, load-use, branch flush,
// forwarding priority, memory wait, timeout and reset out of MEM_WAIT.
module tb_hazard_sequencer;
   import hazard_sequencer_pkg::*;

   logic i_clk;
   logic i_rst;
   int   checks;
   int   errors;

   hazard_sequencer_if bus ();

   hazard_sequencer #(.TIMEOUT(15)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   // Clock and watchdog
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Driver helpers: advance to 1 ns after the rising edge.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_d_rs1 = 5'd0;
      bus.i_d_rs2 = 5'd0;
      bus.i_e_rs1 = 5'd0;
      bus.i_e_rs2 = 5'd0;
      bus.i_e_rd  = 5'd0;
      bus.i_m_rd  = 5'd0;
      bus.i_w_rd  = 5'd0;
      bus.i_m_en_regfile_write     = 1'b0;
      bus.i_w_en_regfile_write     = 1'b0;
      bus.i_e_mux_final_result_src = 2'b00;
      bus.i_pc_src    = 1'b0;
      bus.i_m_mem_req = 1'b0;
      bus.i_mem_ack   = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] stalls_vec();
      return {28'd0, bus.o_f_stall, bus.o_d_stall, bus.o_e_stall, bus.o_m_stall};
   endfunction

   function automatic logic [31:0] clears_vec();
      return {30'd0, bus.o_fd_clr, bus.o_de_clr};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      i_rst  = 1'b0;
      clear_inputs();

      // Reset holds clears high and forwarding off even with a live match.
      tick();
      tick();
      bus.i_m_en_regfile_write = 1'b1;
      bus.i_m_rd  = 5'd7;
      bus.i_e_rs1 = 5'd7;
      bus.i_e_mux_final_result_src = RESULT_SRC_LOAD;
      bus.i_e_rd  = 5'd3;
      bus.i_d_rs1 = 5'd3;
      settle();
      check("rst_state", 32'(bus.o_state), 32'(FILL));
      check("rst_clears", clears_vec(), 32'h3);
      check("rst_stalls", stalls_vec(), 32'h0);
      check("rst_bubble", 32'(bus.o_w_bubble), 32'h0);
      check("rst_fwd_a", 32'(bus.o_fwd_a), 32'(FWD_REGFILE));
      check("rst_cnt", 32'(bus.o_stall_count), 32'h0);
      check("rst_timeout", 32'(bus.o_mem_timeout), 32'h0);

      // Fill: two cycles of clears, then RUN.
      clear_inputs();
      i_rst = 1'b1;
      settle();
      check("fill1_clears", clears_vec(), 32'h3);
      tick();
      check("fill2_clears", clears_vec(), 32'h3);
      check("fill2_state", 32'(bus.o_state), 32'(FILL));
      tick();
      check("run_state", 32'(bus.o_state), 32'(RUN));
      check("run_clears", clears_vec(), 32'h0);
      check("run_stalls", stalls_vec(), 32'h0);

      // Load-use on rs2.
      bus.i_e_mux_final_result_src = RESULT_SRC_LOAD;
      bus.i_e_rd  = 5'd5;
      bus.i_d_rs2 = 5'd5;
      settle();
      check("lu_stalls", stalls_vec(), 32'hC);
      check("lu_clears", clears_vec(), 32'h1);
      tick();
      clear_inputs();
      settle();
      check("lu_cnt", 32'(bus.o_stall_count), 32'd1);
      check("lu_released", stalls_vec(), 32'h0);

      // Load into x0 never stalls.
      bus.i_e_mux_final_result_src = RESULT_SRC_LOAD;
      settle();
      check("lu_x0_stalls", stalls_vec(), 32'h0);
      check("lu_x0_clears", clears_vec(), 32'h0);

      // Branch overrides load-use on rs1.
      bus.i_e_rd   = 5'd9;
      bus.i_d_rs1  = 5'd9;
      bus.i_pc_src = 1'b1;
      settle();
      check("br_clears", clears_vec(), 32'h3);
      check("br_stalls", stalls_vec(), 32'h0);
      tick();
      clear_inputs();
      settle();
      check("br_cnt", 32'(bus.o_stall_count), 32'd1);

      // Forwarding priority and x0 exclusion.
      bus.i_m_rd  = 5'd7;
      bus.i_w_rd  = 5'd7;
      bus.i_e_rs1 = 5'd7;
      bus.i_e_rs2 = 5'd7;
      bus.i_m_en_regfile_write = 1'b1;
      bus.i_w_en_regfile_write = 1'b1;
      settle();
      check("fwd_a_mem", 32'(bus.o_fwd_a), 32'(FWD_MEM));
      check("fwd_b_mem", 32'(bus.o_fwd_b), 32'(FWD_MEM));
      bus.i_m_en_regfile_write = 1'b0;
      settle();
      check("fwd_a_wb", 32'(bus.o_fwd_a), 32'(FWD_WB));
      bus.i_e_rs2 = 5'd8;
      settle();
      check("fwd_b_none", 32'(bus.o_fwd_b), 32'(FWD_REGFILE));
      bus.i_m_en_regfile_write = 1'b1;
      bus.i_w_en_regfile_write = 1'b0;
      bus.i_m_rd  = 5'd0;
      bus.i_e_rs1 = 5'd0;
      settle();
      check("fwd_a_x0", 32'(bus.o_fwd_a), 32'(FWD_REGFILE));
      clear_inputs();

      // Request acked in the same cycle stays in RUN.
      bus.i_m_mem_req = 1'b1;
      bus.i_mem_ack   = 1'b1;
      tick();
      check("ack_same_state", 32'(bus.o_state), 32'(RUN));

      // Ack arriving after three wait cycles.
      bus.i_mem_ack = 1'b0;
      settle();
      check("req_no_stall", stalls_vec(), 32'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) bus.i_mem_ack = 1'b1;
         settle();
         check("mw_stalls", stalls_vec(), 32'hF);
         check("mw_bubble", 32'(bus.o_w_bubble), 32'h1);
         check("mw_clears", clears_vec(), 32'h0);
         tick();
      end
      clear_inputs();
      settle();
      check("mw_back_run", 32'(bus.o_state), 32'(RUN));
      check("mw_released", stalls_vec(), 32'h0);
      check("mw_cnt", 32'(bus.o_stall_count), 32'd4);
      check("mw_no_timeout", 32'(bus.o_mem_timeout), 32'h0);

      // Timeout: flag clear after 14 wait cycles, set after 15, sticky.
      bus.i_m_mem_req = 1'b1;
      tick();
      for (int i = 0; i < 14; i++) tick();
      check("to_14", 32'(bus.o_mem_timeout), 32'h0);
      tick();
      check("to_15", 32'(bus.o_mem_timeout), 32'h1);
      check("to_state", 32'(bus.o_state), 32'(MEM_WAIT));
      bus.i_mem_ack = 1'b1;
      tick();
      clear_inputs();
      settle();
      check("to_run", 32'(bus.o_state), 32'(RUN));
      check("to_sticky", 32'(bus.o_mem_timeout), 32'h1);
      check("to_cnt", 32'(bus.o_stall_count), 32'd20);

      // Reset out of MEM_WAIT.
      bus.i_m_mem_req = 1'b1;
      tick();
      tick();
      check("rmw_state", 32'(bus.o_state), 32'(MEM_WAIT));
      i_rst = 1'b0;
      settle();
      check("rmw_stalls", stalls_vec(), 32'h0);
      check("rmw_clears", clears_vec(), 32'h3);
      check("rmw_bubble", 32'(bus.o_w_bubble), 32'h0);
      tick();
      check("rmw_fill", 32'(bus.o_state), 32'(FILL));
      check("rmw_cnt", 32'(bus.o_stall_count), 32'h0);
      check("rmw_timeout", 32'(bus.o_mem_timeout), 32'h0);
      clear_inputs();
      i_rst = 1'b1;
      tick();
      tick();
      check("rmw_refill_run", 32'(bus.o_state), 32'(RUN));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15, meaning the number of MEM_WAIT cycles after which the memory-timeout flag sets (range 1..15).
REQ-002 SHALL provide i_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL provide i_rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL provide i_d_rs1, i_d_rs2  in  5 each  decode-stage source registers.
REQ-005 SHALL provide i_e_rs1, i_e_rs2, i_e_rd  in  5 each  exec-stage sources and destination.
REQ-006 SHALL provide i_m_rd, i_w_rd  in  5 each  mem and writeback destinations.
REQ-007 SHALL provide i_m_en_regfile_write, i_w_en_regfile_write  in  1 each  mem/wb write enables.
REQ-008 SHALL provide i_e_mux_final_result_src  in  2  exec result select; 2'b01 marks a load.
REQ-009 SHALL provide i_pc_src  in  1  branch/jump taken, resolved in exec.
REQ-010 SHALL provide i_m_mem_req  in  1  mem stage holds a load/store; i_mem_ack  in  1  data memory completes the access this cycle.
REQ-011 SHALL provide o_f_stall, o_d_stall, o_e_stall, o_m_stall  out  1 each  hold the stage register.
REQ-012 SHALL provide o_fd_clr, o_de_clr  out  1 each  flush fetch->decode and decode->exec registers.
REQ-013 SHALL provide o_w_bubble  out  1  suppress writeback this cycle.
REQ-014 SHALL provide o_fwd_a, o_fwd_b  out  2 each  exec operand source: 00 regfile, 01 wb result, 10 mem ALU result.
REQ-015 SHALL provide o_mem_timeout  out  1  sticky memory-timeout flag; o_stall_count  out  16  saturating count of stall cycles.

Function
REQ-016 SHALL implement FSM states FILL, RUN, MEM_WAIT.
REQ-017 FILL SHALL last exactly 2 cycles (2-bit counter), asserting o_fd_clr and o_de_clr, then go to RUN.
REQ-018 RUN->MEM_WAIT SHALL occur when i_m_mem_req=1 and i_mem_ack=0; with i_mem_ack=1 in the same cycle the FSM SHALL stay in RUN.
REQ-019 MEM_WAIT SHALL assert all four stage stalls and o_w_bubble, deassert both clears, and return to RUN in the cycle after i_mem_ack=1.
REQ-020 MEM_WAIT SHALL count cycles in a 4-bit counter; on reaching TIMEOUT it SHALL set o_mem_timeout, stop incrementing, and stay in MEM_WAIT until ack.
REQ-021 In RUN, load-use (i_e_mux_final_result_src=01, i_e_rd!=0, i_e_rd equal to i_d_rs1 or i_d_rs2) SHALL assert o_f_stall, o_d_stall and o_de_clr for one cycle.
REQ-022 In RUN, i_pc_src=1 SHALL assert o_fd_clr and o_de_clr and SHALL override a simultaneous load-use (no stall asserted).
REQ-023 Forwarding SHALL be combinational: o_fwd_a=10 if i_m_en_regfile_write and i_m_rd!=0 and i_m_rd==i_e_rs1; else 01 under the same rule for w; else 00; o_fwd_b identical on i_e_rs2; mem has priority over wb.
REQ-024 Register x0 SHALL never match for load-use or forwarding.
REQ-025 o_stall_count SHALL increment each cycle o_f_stall=1, saturating at 16'hFFFF.
REQ-026 All stall/clear outputs SHALL be combinational from state and inputs (zero latency).

Reset
REQ-027 i_rst=0 at a clock edge SHALL force state FILL with fill counter 0, wait counter 0, o_mem_timeout=0, o_stall_count=0, including mid-MEM_WAIT.
REQ-028 During reset, stalls, o_w_bubble and o_fwd_a/o_fwd_b SHALL be 0, and o_fd_clr/o_de_clr SHALL be 1.

Structure
REQ-029 The state enum, the forwarding encodings and the load result-select value 2'b01 SHALL live in the shared control package.
REQ-030 Forwarding logic SHALL be one sub-module, forward_unit; the FSM and counters SHALL stay in hazard_sequencer.

Verification
REQ-031 Release reset -> clears high for exactly 2 cycles, then state RUN with all stalls 0.
REQ-032 Load in E with rd=5 and D rs2=5 -> one cycle of f/d stall plus de_clr, o_stall_count=1; the same case with rd=0 -> no stall.
REQ-033 i_pc_src=1 while load-use is true -> fd_clr=de_clr=1 and stalls 0.
REQ-034 m_rd=w_rd=e_rs1=7 with both write enables set -> o_fwd_a=10; clear the mem write enable -> o_fwd_a=01.
REQ-035 mem_req with ack delayed 3 cycles -> 3 cycles of all stalls and w_bubble, RUN on the 4th; ack withheld 15 cycles -> o_mem_timeout=1, which persists after ack.
REQ-036 Reset asserted in MEM_WAIT -> next state FILL and counters/flags 0.
